// File: rtl/conv_mem_arbiter.sv
// rtl/conv_mem_arbiter.sv - round-robin burst arbiter for the convolution engine's single-port memory
// Ports: 0 filter read, 1 image read, 2 result write; each grant costs L+2 cycles.
module conv_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*LEN_W-1:0]    req_len,
  input  logic [DATA_W-1:0]     res_wdata,
  output logic [2:0]            gnt,
  output logic [2:0]            beat,
  output logic [2:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic [2:0]            burst_done,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [1:0] {IDLE, GRANT, BURST, DRAIN} state_t;

  state_t            state, state_next;
  logic [1:0]        ptr, owner, win, idx;
  logic              win_valid;
  logic [2:0]        cand, owner_oh;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  len_m1, cnt, len_in;
  logic              last_beat;

  assign owner_oh  = 3'b001 << owner;
  assign last_beat = (cnt == len_m1);
  assign len_in    = req_len[owner*LEN_W +: LEN_W];
  assign rdata     = mem_rdata;

  // The finishing owner is masked in DRAIN so it cannot immediately re-win.
  always_comb begin
    cand      = req;
    win       = ptr;
    win_valid = 1'b0;
    idx       = '0;
    if (state == DRAIN) cand = req & ~owner_oh;
    for (int i = 1; i <= 3; i++) begin
      idx = 2'((int'(ptr) + i) % 3);
      if (!win_valid && cand[idx]) begin
        win       = idx;
        win_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    gnt        = '0;
    beat       = '0;
    burst_done = '0;
    busy       = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        if (win_valid) state_next = GRANT;
      end
      GRANT: begin
        busy       = 1'b1;
        gnt        = owner_oh;
        state_next = BURST;
      end
      BURST: begin
        busy     = 1'b1;
        gnt      = owner_oh;
        beat     = owner_oh;
        mem_en   = 1'b1;
        mem_addr = base + ADDR_W'(cnt);
        if (owner == 2'd2) begin
          mem_we    = 1'b1;
          mem_wdata = res_wdata;
        end
        if (last_beat) begin
          burst_done = owner_oh;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy       = 1'b1;
        gnt        = owner_oh;
        state_next = win_valid ? GRANT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Base and length are captured once in GRANT so requesters may change them freely afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr    <= 2'd2;
      owner  <= 2'd0;
      base   <= '0;
      len_m1 <= '0;
      cnt    <= '0;
      rvalid <= '0;
    end else begin
      if ((state == IDLE || state == DRAIN) && win_valid) owner <= win;
      if (state == GRANT) begin
        ptr    <= owner;
        base   <= req_addr[owner*ADDR_W +: ADDR_W];
        len_m1 <= (len_in == '0) ? '0 : len_in - 1'b1;
        cnt    <= '0;
      end else if (state == BURST) begin
        cnt <= cnt + 1'b1;
      end
      rvalid <= (state == BURST && owner != 2'd2) ? owner_oh : 3'b000;
    end
  end

endmodule

// File: tb/tb_conv_mem_arbiter.sv
// tb/tb_conv_mem_arbiter.sv - directed bench for conv_mem_arbiter
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_conv_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [2:0]          req;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*LEN_W-1:0]  req_len;
  logic [DATA_W-1:0]   res_wdata;
  logic [2:0]          gnt, beat, rvalid, burst_done;
  logic [DATA_W-1:0]   rdata;
  logic                busy, mem_en, mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata = '0;

  int n_cmp = 0;
  int n_err = 0;

  conv_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_len(req_len),
    .res_wdata(res_wdata), .gnt(gnt), .beat(beat), .rvalid(rvalid), .rdata(rdata),
    .burst_done(burst_done), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: each word reads back as 0xDA7A followed by its address.
  always @(posedge clk) mem_rdata <= {16'hDA7A, mem_addr};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    req_addr[p*ADDR_W +: ADDR_W] = a;
    req_len[p*LEN_W +: LEN_W]    = l;
  endtask

  function automatic logic [63:0] all_out();
    return {1'b0, gnt, beat, rvalid, burst_done, busy, mem_en, mem_we, mem_addr, mem_wdata};
  endfunction

  initial begin
    logic [2:0] oh;
    rst       = 1'b0;
    req       = '0;
    req_addr  = '0;
    req_len   = '0;
    res_wdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", all_out(), 64'd0);
    rst = 1'b1;
    tick();
    chk("idle_busy", {63'd0, busy}, 64'd0);

    // Filter read, len 4, base 0x0010
    set_port(0, 16'h0010, 5'd4);
    req = 3'b001;
    tick();
    chk("t1_gnt", {61'd0, gnt}, 64'd1);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    chk("t1_grant_no_mem", {63'd0, mem_en}, 64'd0);
    req = 3'b000;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_addr", {48'd0, mem_addr}, 64'(16'h0010 + k));
      chk("t1_en_we", {62'd0, mem_en, mem_we}, 64'b10);
      chk("t1_beat", {61'd0, beat}, 64'd1);
      chk("t1_done", {61'd0, burst_done}, (k == 3) ? 64'd1 : 64'd0);
      chk("t1_rvalid", {61'd0, rvalid}, (k == 0) ? 64'd0 : 64'd1);
      if (k > 0) chk("t1_rdata", {32'd0, rdata}, 64'(32'hDA7A_0010 + k - 1));
    end
    tick();
    chk("t1_drain_rvalid", {61'd0, rvalid}, 64'd1);
    chk("t1_drain_rdata", {32'd0, rdata}, 64'h0000_0000_DA7A_0013);
    chk("t1_drain_state", {58'd0, gnt, beat}, {58'd0, 3'b001, 3'b000});
    tick();
    chk("t1_idle", {57'd0, busy, gnt, rvalid}, 64'd0);

    // Round robin with all three requesting, len 1 each, from reset
    rst = 1'b0;
    settle();
    chk("rr_reset", all_out(), 64'd0);
    tick();
    rst = 1'b1;
    set_port(0, 16'h0100, 5'd1);
    set_port(1, 16'h0110, 5'd1);
    set_port(2, 16'h0120, 5'd1);
    req = 3'b111;
    for (int g = 0; g < 6; g++) begin
      oh = 3'b001 << (g % 3);
      tick();
      chk("rr_grant", {58'd0, gnt, beat}, {58'd0, oh, 3'b000});
      tick();
      chk("rr_beat", {58'd0, beat, burst_done}, {58'd0, oh, oh});
      tick();
      chk("rr_drain", {58'd0, gnt, beat}, {58'd0, oh, 3'b000});
      if (g == 5) req = 3'b000;
    end
    tick();
    chk("rr_idle", {63'd0, busy}, 64'd0);

    // Result write wrapping from 0xFFFF
    set_port(2, 16'hFFFF, 5'd2);
    res_wdata = 32'hA5A5_A5A5;
    req = 3'b100;
    tick();
    chk("wr_gnt", {61'd0, gnt}, 64'b100);
    req = 3'b000;
    tick();
    chk("wr_beat0", {13'd0, beat, mem_we, mem_addr, mem_wdata}, {13'd0, 3'b100, 1'b1, 16'hFFFF, 32'hA5A5_A5A5});
    res_wdata = 32'h5A5A_5A5A;
    tick();
    chk("wr_beat1", {13'd0, burst_done, mem_we, mem_addr, mem_wdata}, {13'd0, 3'b100, 1'b1, 16'h0000, 32'h5A5A_5A5A});
    chk("wr_rvalid1", {61'd0, rvalid}, 64'd0);
    tick();
    chk("wr_drain", {29'd0, rvalid, mem_we, mem_wdata}, 64'd0);
    tick();
    chk("wr_idle", {63'd0, busy}, 64'd0);

    // Port 1 with req_len 0 behaves as a single beat
    set_port(1, 16'h0200, 5'd0);
    req = 3'b010;
    tick();
    chk("len0_gnt", {61'd0, gnt}, 64'b010);
    req = 3'b000;
    tick();
    chk("len0_beat", {42'd0, beat, burst_done, mem_addr}, {42'd0, 3'b010, 3'b010, 16'h0200});
    tick();
    chk("len0_drain", {32'd0, 3'b000, beat, rvalid, 23'd0}, {32'd0, 3'b000, 3'b000, 3'b010, 23'd0});
    chk("len0_rdata", {32'd0, rdata}, 64'h0000_0000_DA7A_0200);
    tick();
    chk("len0_idle", {63'd0, busy}, 64'd0);

    // Reset mid-burst of a len 8 read, then port 1 wins first
    set_port(0, 16'h0300, 5'd8);
    req = 3'b001;
    tick();
    req = 3'b000;
    repeat (3) tick();
    chk("abort_pre_beat", {61'd0, beat}, 64'b001);
    rst = 1'b0;
    settle();
    chk("abort_outputs", all_out(), 64'd0);
    set_port(1, 16'h0210, 5'd1);
    set_port(2, 16'h0220, 5'd1);
    req = 3'b110;
    tick();
    chk("abort_held", all_out(), 64'd0);
    rst = 1'b1;
    tick();
    chk("abort_first_winner", {61'd0, gnt}, 64'b010);
    req = 3'b000;
    repeat (3) tick();
    chk("abort_idle", {63'd0, busy}, 64'd0);

    // Port 0 drops req after beat 2 of a len 6 read; pending port 2 follows
    set_port(0, 16'h0400, 5'd6);
    set_port(2, 16'h0500, 5'd1);
    req = 3'b001;
    tick();
    chk("drop_gnt", {61'd0, gnt}, 64'b001);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("drop_beat", {45'd0, beat, mem_addr}, {45'd0, 3'b001, 16'(16'h0400 + k)});
      chk("drop_rvalid", {61'd0, rvalid}, (k == 0) ? 64'd0 : 64'd1);
      chk("drop_done", {61'd0, burst_done}, (k == 5) ? 64'd1 : 64'd0);
      if (k == 1) req = 3'b100;
    end
    tick();
    chk("drop_drain", {58'd0, gnt, rvalid}, {58'd0, 3'b001, 3'b001});
    tick();
    chk("drop_next_gnt", {61'd0, gnt}, 64'b100);
    req = 3'b000;
    tick();
    chk("drop_next_beat", {44'd0, beat, mem_we, mem_addr}, {44'd0, 3'b100, 1'b1, 16'h0500});
    tick();
    tick();
    chk("drop_idle", {63'd0, busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_mem_arbiter.md
# conv_mem_arbiter

Round-robin arbiter sharing the convolution engine's single-port memory between three burst requesters: filter loader (port 0, read), image-slice loader (port 1, read) and result write-back (port 2, write). It sits between the convolution controller's load and store paths and the memory. It converts each granted request into a burst of one-word-per-cycle memory accesses at consecutive addresses, and routes read data and per-beat strobes back to the owning requester.

## Interface
- ADDR_W, 16, memory address width
- DATA_W, 32, memory word width
- LEN_W, 5, burst-length field width (max burst 2^LEN_W - 1 words)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- req  in  3  burst request; bit0 filter, bit1 image, bit2 result
- req_addr  in  3*ADDR_W  base address per requester, slice i = [i*ADDR_W +: ADDR_W]
- req_len  in  3*LEN_W  burst length in words per requester; 0 treated as 1
- res_wdata  in  DATA_W  write data from result requester, consumed on each of its beats
- gnt  out  3  one-hot grant, held from GRANT through DRAIN
- beat  out  3  one-cycle strobe per issued memory access of the granted port
- rvalid  out  3  read data valid, one cycle after a read beat
- rdata  out  DATA_W  mem_rdata passthrough
- burst_done  out  3  one-cycle pulse coincident with the last beat
- busy  out  1  high in any state except IDLE
- mem_en  out  1  memory access enable
- mem_we  out  1  write enable, high only on port-2 beats
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  DATA_W  equals res_wdata on write beats, else 0
- mem_rdata  in  DATA_W  read data, valid one cycle after mem_en with mem_we=0

## Operation
- FSM states: IDLE, GRANT, BURST, DRAIN.
- IDLE: if any unmasked req bit is set, choose the winner, then go to GRANT. Otherwise stay in IDLE.
- GRANT (1 cycle): latch winner id, base address and length (0 becomes 1); reset the beat counter; raise gnt[winner]; go to BURST.
- BURST: one beat per cycle, for L cycles. Each beat drives mem_en=1, mem_addr=base+k with k=0..L-1, and beat[winner]=1. On the last beat, pulse burst_done[winner], then go to DRAIN.
- DRAIN (1 cycle): delivers rvalid for the final read. In this cycle, arbitrate with the current owner's req masked. Any winner goes to GRANT; no winner goes to IDLE.
- Round-robin: a last-served pointer is updated in GRANT. The search starts at pointer+1 mod 3. The reset value of the pointer is 2, so port 0 wins first.
- Latched base and length are immune to input changes. Deasserting req mid-burst does not shorten the burst.
- Address arithmetic is modulo 2^ADDR_W; base + k wraps silently.
- Write beats: mem_we=1 and mem_wdata=res_wdata in the same cycle. The requester presents word k while beat[2] is high.
- Read beats: rvalid[winner] is high the cycle after each beat, with rdata=mem_rdata.
- Requesters must deassert req within one cycle after burst_done. Requests raised during BURST wait until the next arbitration point.

## Timing
- Reset (rst=0) immediately forces the following, regardless of state:
  - state IDLE and pointer=2
  - all outputs 0, including gnt, beat, rvalid, burst_done, busy, mem_en, mem_we, mem_addr, mem_wdata
  - rdata is the mem_rdata passthrough and is not forced
- Reset mid-burst aborts the burst. No burst_done is issued.
- req seen in IDLE at cycle T:
  - GRANT at T+1, with gnt and busy high
  - beats at T+2..T+1+L, with burst_done at T+1+L
  - DRAIN at T+2+L, carrying the last rvalid for reads
  - IDLE, or GRANT for the next requester, at T+3+L
- Back-to-back bursts: one GRANT bubble plus one DRAIN cycle between the last beat of one burst and the first beat of the next.
- Total occupancy for a burst is L+2 cycles.

## Test plan
- Filter read, req_len=4, base 0x0010, req[0] at T: gnt[0] at T+1; mem_addr 0x10,0x11,0x12,0x13 at T+2..T+5 with mem_we=0; rvalid[0] at T+3..T+6; burst_done[0] at T+5; busy low at T+7.
- req=3'b111 held continuously after reset, each len=1: grant order 0,1,2,0,1,2. Each grant lasts 3 cycles (GRANT, BURST, DRAIN).
- Result write, ADDR_W=16, base 0xFFFF, len=2, res_wdata 0xA5A5A5A5 then 0x5A5A5A5A: mem_addr 0xFFFF then 0x0000; mem_we=1 on both beats; mem_wdata matches; rvalid stays 0.
- req_len=0 on port 1: exactly one beat, and burst_done[1] coincides with it.
- rst driven low mid-BURST of a len=8 read: all outputs 0 in the same cycle, with no burst_done. After release, with req=3'b110, port 1 wins first.
- req[0] dropped after the second beat of a len=6 read: all 6 beats and 6 rvalids still occur. Port 0's req is ignored in DRAIN, so a pending req[2] is granted next.
